hamming_top_level: RTL and testbench



---
 rtl/hamming_top_level.sv | 128 ++++++++++++
 tb/tb_hamming_top_level.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/hamming_top_level.sv
// Hamming SECDED (16,11) encoder engine with a private 256x8 data memory.
// Optional build macro ACK_PULSE_EN: ack becomes a one-cycle pulse and the FSM returns to IDLE.

module data_mem (
  input  logic       clk,
  input  logic       wr_en,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [7:0] rd_addr,
  output logic [7:0] rd_data
);

  // Contents are deliberately never reset so externally preloaded bytes survive reset.
  logic [7:0] core [256];

  assign rd_data = core[rd_addr];

  always_ff @(posedge clk) begin
    if (wr_en) core[wr_addr] <= wr_data;
  end

endmodule

module hamming_top_level #(
  parameter int NUM_MSG  = 15,
  parameter int OUT_BASE = 30
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic ack
);

  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE} state_t;

  state_t     state, state_next;
  logic [6:0] idx, idx_next;
  logic       ack_next;
  logic [7:0] lo_byte;
  logic [2:0] hi_bits;

  logic       wr_en;
  logic [7:0] wr_addr, wr_data, rd_addr, rd_data;
  logic [11:1] d;
  logic [15:0] codeword;
  logic       p8, p4, p2, p1, p0;

  data_mem dm1 (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Message i lives at bytes 2i/2i+1; its codeword goes to OUT_BASE+2i/OUT_BASE+2i+1.
  assign rd_addr = {idx, (state == RD_HI)};
  assign wr_addr = 8'(OUT_BASE) + {idx, (state == WR_HI)};
  assign wr_en   = (state == WR_LO) || (state == WR_HI);

  assign d  = {hi_bits, lo_byte};
  assign p8 = ^d[11:5];
  assign p4 = (^d[11:8]) ^ (^d[4:2]);
  assign p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
  assign p1 = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
  assign p0 = (^d) ^ p8 ^ p4 ^ p2 ^ p1;

  assign codeword = {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0};
  assign wr_data  = (state == WR_HI) ? codeword[15:8] : codeword[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      ack     <= 1'b0;
      lo_byte <= '0;
      hi_bits <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      ack   <= ack_next;
      if (state == RD_LO) lo_byte <= rd_data;
      if (state == RD_HI) hi_bits <= rd_data[2:0];
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    ack_next   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RD_LO;
          idx_next   = '0;
        end
      end
      RD_LO: state_next = RD_HI;
      RD_HI: state_next = WR_LO;
      WR_LO: state_next = WR_HI;
      WR_HI: begin
        if (idx == 7'(NUM_MSG - 1)) begin
          ack_next = 1'b1;
`ifdef ACK_PULSE_EN
          state_next = IDLE;
`else
          state_next = DONE;
`endif
        end else begin
          idx_next   = idx + 7'd1;
          state_next = RD_LO;
        end
      end
      DONE: begin
        // A new start restarts from message 0; otherwise ack is held.
        if (start) begin
          state_next = RD_LO;
          idx_next   = '0;
        end else begin
          ack_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_hamming_top_level.sv
// Randomized self-checking bench for hamming_top_level using a positional Hamming reference model.

module tb_hamming_top_level;

  logic clk;
  logic rst_n;
  logic start;
  logic ack;

  int errorCount = 0;
  int checkCount = 0;

  logic [15:0] msgRaw [15];
  logic [7:0]  highShadow [256];

  hamming_top_level #(.NUM_MSG(15), .OUT_BASE(30)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .ack   (ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", tag, actual, expected);
    end
  endtask

  // Data bits fill the non-power-of-two positions 3..15 in order; parity bit at 2^b covers positions with bit b set.
  function automatic logic [15:0] encodeRef(input logic [10:0] data);
    logic [15:0] cw;
    logic        p;
    int          k;
    cw = '0;
    k  = 0;
    for (int pos = 1; pos < 16; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        cw[pos] = data[k];
        k++;
      end
    end
    for (int b = 0; b < 4; b++) begin
      p = 1'b0;
      for (int pos = 1; pos < 16; pos++)
        if (((pos >> b) & 1) == 1) p = p ^ cw[pos];
      cw[1 << b] = p;
    end
    cw[0] = ^cw[15:1];
    return cw;
  endfunction

  function automatic logic [15:0] readCodeword(input int i);
    return {dut.dm1.core[31 + 2*i], dut.dm1.core[30 + 2*i]};
  endfunction

  task automatic loadMessages();
    for (int i = 0; i < 15; i++) begin
      dut.dm1.core[2*i]     = msgRaw[i][7:0];
      dut.dm1.core[2*i + 1] = msgRaw[i][15:8];
    end
  endtask

  task automatic randomMessages();
    for (int i = 0; i < 15; i++) msgRaw[i] = 16'($urandom);
  endtask

  task automatic fillOutputs(input logic [7:0] value);
    for (int a = 30; a < 60; a++) dut.dm1.core[a] = value;
  endtask

  task automatic checkCodewords(input string tag, input int count);
    for (int i = 0; i < count; i++)
      checkOutput($sformatf("%s_cw%0d", tag, i), 32'(readCodeword(i)),
                  32'(encodeRef({msgRaw[i][10:8], msgRaw[i][7:0]})));
  endtask

  task automatic checkUntouched(input string tag);
    int diffs;
    diffs = 0;
    for (int i = 0; i < 15; i++) begin
      if (dut.dm1.core[2*i] !== msgRaw[i][7:0]) diffs++;
      if (dut.dm1.core[2*i + 1] !== msgRaw[i][15:8]) diffs++;
    end
    for (int a = 60; a < 256; a++)
      if (dut.dm1.core[a] !== highShadow[a]) diffs++;
    checkOutput($sformatf("%s_untouched", tag), 32'(diffs), 32'd0);
  endtask

  // Pulses start (held for 'hold' edges, plus an extra pulse at edge extraAt) and measures edges until ack.
  task automatic applyStimulus(input string tag, input int hold, input int extraAt);
    int n;
    int lat;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    checkOutput($sformatf("%s_ack_after_start", tag), 32'(ack), 32'd0);
    n   = 0;
    lat = -1;
    while (n < 100 && lat < 0) begin
      @(negedge clk);
      start = ((n + 1) < hold) || ((n + 1) == extraAt);
      @(posedge clk);
      n++;
      #1;
      if (ack) lat = n;
    end
    @(negedge clk);
    start = 1'b0;
    checkOutput($sformatf("%s_latency", tag), 32'(lat), 32'd60);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    for (int a = 0; a < 256; a++) begin
      highShadow[a]    = 8'($urandom);
      dut.dm1.core[a]  = highShadow[a];
    end
    #12;
    checkOutput("reset_ack", 32'(ack), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("idle_ack", 32'(ack), 32'd0);

    // Directed vectors, rest random with junk in the ignored upper bits.
    randomMessages();
    msgRaw[0] = 16'h0000;
    msgRaw[1] = 16'h07FF;
    msgRaw[2] = 16'hFFFF;
    msgRaw[3] = 16'h0001;
    msgRaw[4] = 16'h0010;
    msgRaw[5] = 16'h0400;
    loadMessages();
    fillOutputs(8'h5A);
    applyStimulus("directed", 1, -1);
    checkOutput("dir_zero",   32'(readCodeword(0)), 32'h0000);
    checkOutput("dir_all",    32'(readCodeword(1)), 32'hFFFF);
    checkOutput("dir_upper",  32'(readCodeword(2)), 32'hFFFF);
    checkOutput("dir_d1",     32'(readCodeword(3)), 32'h000F);
    checkOutput("dir_d5",     32'(readCodeword(4)), 32'h0303);
    checkOutput("dir_d11",    32'(readCodeword(5)), 32'h8117);
    checkCodewords("directed", 15);
    checkUntouched("directed");
    repeat (3) @(posedge clk);
    #1;
`ifdef ACK_PULSE_EN
    checkOutput("ack_after_done", 32'(ack), 32'd0);
`else
    checkOutput("ack_after_done", 32'(ack), 32'd1);
`endif

    // Random messages, started from DONE (level build), with start held for three edges.
    randomMessages();
    loadMessages();
    fillOutputs(8'hC3);
    applyStimulus("random", 3, -1);
    checkCodewords("random", 15);
    checkUntouched("random");

    // Reset after E20: messages 0..4 are written, the rest untouched.
    randomMessages();
    loadMessages();
    fillOutputs(8'hAA);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_ack", 32'(ack), 32'd0);
    checkCodewords("midrst_kept", 5);
    checkOutput("midrst_unwritten", 32'({dut.dm1.core[41], dut.dm1.core[40]}), 32'hAAAA);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("midrst_idle_ack", 32'(ack), 32'd0);
    checkOutput("midrst_idle_nowrite", 32'(dut.dm1.core[59]), 32'hAA);
    msgRaw[0] = 16'($urandom);
    loadMessages();
    applyStimulus("rerun", 1, -1);
    checkCodewords("rerun", 15);
    checkUntouched("rerun");

    // A second start at edge 10 is ignored; then repeat the run from DONE with identical data.
    randomMessages();
    loadMessages();
    fillOutputs(8'h00);
    applyStimulus("extra_start", 1, 10);
    checkCodewords("extra_start", 15);
    applyStimulus("repeat", 1, -1);
    checkCodewords("repeat", 15);
    checkUntouched("repeat");

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
